pingpong_sram_buffer: RTL and testbench
=======================================

Name: pingpong_sram_buffer

Overview:
Parametrised double-buffered SRAM store that sits between the DMA fill engine and the PE array read port. It holds two halves (A, B) of LANES single-port SRAM macros each. The producer fills one half while the consumer drains the other. Half ownership is tracked by an internal per-half state machine with explicit fill/drain handshakes, so no external select signal is used. Read data is returned with fixed 1-cycle latency, tagged per lane.

Parameters:
LANES, 8, SRAM macros per half (one per lane)
DW, 128, data width per lane (bits)
DEPTH, 128, words per macro
AW, $clog2(DEPTH), address width (derived localparam, not overridable)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  reset rst, synchronous, active-high
wr_en  in  LANES  per-lane write strobe, same address for all lanes
wr_addr  in  AW  write word address
wr_data  in  LANES*DW  lane l at bits [l*DW +: DW]
wr_last  in  1  qualifies the final write of a fill; meaningful only with an accepted write
wr_ready  out  1  fill half is writable
rd_en  in  LANES  per-lane read strobe
rd_addr  in  LANES*AW  per-lane read address
rd_done  in  1  single-cycle pulse: consumer finished the current read half
rd_ready  out  1  read half holds a complete fill
rd_valid  out  LANES  per-lane read data valid
rd_data  out  LANES*DW  per-lane read data
full_cnt  out  2  number of halves in FULL or DRAINING state (0..2)
err  out  1  sticky protocol-error flag, cleared only by rst

Behaviour:
- Per-half state: EMPTY -> FILLING (first accepted write) -> FULL (accepted write with wr_last) -> DRAINING (first accepted read, or stays FULL) -> EMPTY (rd_done). A FULL half goes straight to EMPTY on rd_done if it was never read.
- wr_ptr selects the fill half and rd_ptr selects the read half. Both reset to half A.
- wr_ready = 1 when the fill half is EMPTY or FILLING.
- A write is accepted when |wr_en && wr_ready. On an accepted write with wr_last, the half goes to FULL and wr_ptr toggles on the same edge.
- rd_ready = 1 when the read half is FULL or DRAINING.
- A read on lane l is accepted when rd_en[l] && rd_ready. Read-half selection is registered at issue time.
- On the next cycle, rd_valid[l] = 1 and rd_data lane l holds Q from the selected half. Lanes not read in that cycle have rd_valid = 0 and rd_data held at its previous value.
- rd_done while rd_ready sets the half to EMPTY and toggles rd_ptr. Reads issued in the same cycle still complete from the old half.
- Writes while wr_ready = 0 are dropped. No SRAM access occurs and err is set.
- Reads while rd_ready = 0 are dropped. rd_valid stays 0 and err is set.
- rd_done while rd_ready = 0 is ignored and err is set.
- Any address >= DEPTH (for non-power-of-2 DEPTH) is dropped for that access and err is set.
- Simultaneous wr_last and rd_done on different halves: both state updates apply on the same edge, and full_cnt reflects the net change (+1 then -1 gives no change).
- wr_last without any wr_en is ignored.
- SRAM pins: CEN and WEN are active-low. CEN_n = 0 only for an accepted access on that lane and half. OEN is tied low. Each half's macros are driven only while that half is selected, otherwise idle (CEN = 1).
- Reset values: wr_ptr = rd_ptr = A, both halves EMPTY, wr_ready = 1, rd_ready = 0, rd_valid = 0, rd_data = 0, full_cnt = 0, err = 0.
- Reset mid-operation discards all state at the next edge. SRAM contents are not cleared, and in-flight reads produce no rd_valid.

Decomposition:
- Package pingpong_buf_pkg: half_state_e enum {EMPTY, FILLING, FULL, DRAINING} and half_sel_e {HALF_A, HALF_B}.
- Sub-module pingpong_half_fsm, instantiated twice: inputs are the write-accept, last, read-accept and done strobes for its half; outputs are the state and the ready terms.
- SRAM macros are instantiated directly in generate loops (2 x LANES).

Test Plan:
- Fill A lanes 0-7 at addr 0..127 with data = {lane, addr}, wr_last at 127 -> wr_ptr = B, rd_ready = 1, full_cnt = 1. Then read lane 3 at addr 5 -> rd_valid[3] = 1 one cycle later with data {3, 5}.
- Fill A and fill B with no rd_done -> wr_ready = 0 and full_cnt = 2. A further write -> dropped, err = 1, contents unchanged.
- Drain A with rd_done on the same cycle as a read of addr 9 -> data returns from A, rd_ptr = B, and the next read returns B data.
- wr_last on B in the same cycle as rd_done on A -> full_cnt stays 1, A is EMPTY, B is FULL.
- rd_en on all lanes after reset -> rd_valid stays 0 and err = 1.
- rst asserted mid-fill of B -> next cycle all outputs at reset values; a fresh fill of A succeeds.

Source files
------------

// File: rtl/pingpong_buf_pkg.sv
// Shared types for the ping-pong SRAM buffer.
// Half lifecycle states and half selectors.
package pingpong_buf_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } half_state_e;

    typedef enum logic {
        HALF_A,
        HALF_B
    } half_sel_e;

    function automatic half_sel_e other_half(input half_sel_e h);
        return (h == HALF_A) ? HALF_B : HALF_A;
    endfunction

endpackage

// File: rtl/pingpong_half_fsm.sv
// Ownership state machine for one buffer half.
// Ready terms are registered alongside the state.
module pingpong_half_fsm
    import pingpong_buf_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_acc,
    input  logic        wr_last,
    input  logic        rd_acc,
    input  logic        done,
    output half_state_e state,
    output logic        wr_ok,
    output logic        rd_ok
);

    half_state_e nxt;

    always_comb begin
        nxt = state;
        unique case (state)
            EMPTY: begin
                if (wr_acc)
                    nxt = wr_last ? FULL : FILLING;
            end
            FILLING: begin
                if (wr_acc && wr_last)
                    nxt = FULL;
            end
            FULL: begin
                if (done)
                    nxt = EMPTY;
                else if (rd_acc)
                    nxt = DRAINING;
            end
            DRAINING: begin
                if (done)
                    nxt = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            wr_ok <= 1'b1;
            rd_ok <= 1'b0;
        end else begin
            state <= nxt;
            wr_ok <= (nxt == EMPTY) || (nxt == FILLING);
            rd_ok <= (nxt == FULL) || (nxt == DRAINING);
        end
    end

endmodule

// File: rtl/pingpong_sram_macro.sv
// Behavioural single-port SRAM macro with active-low CEN/WEN/OEN.
// Q holds the last read word until the next read.
module pingpong_sram_macro #(
    parameter  int DW    = 128,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          cen,
    input  logic          wen,
    input  logic          oen,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q_r;

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen)
                mem[a] <= d;
            else
                q_r <= mem[a];
        end
    end

    assign q = oen ? '0 : q_r;

endmodule

// File: rtl/pingpong_sram_buffer.sv
// Double-buffered SRAM store: producer fills one half while the
// consumer drains the other, ownership tracked per half.
module pingpong_sram_buffer
    import pingpong_buf_pkg::*;
#(
    parameter  int LANES = 8,
    parameter  int DW    = 128,
    parameter  int DEPTH = 128,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LANES-1:0]    wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [LANES*DW-1:0] wr_data,
    input  logic                wr_last,
    output logic                wr_ready,
    input  logic [LANES-1:0]    rd_en,
    input  logic [LANES*AW-1:0] rd_addr,
    input  logic                rd_done,
    output logic                rd_ready,
    output logic [LANES-1:0]    rd_valid,
    output logic [LANES*DW-1:0] rd_data,
    output logic [1:0]          full_cnt,
    output logic                err
);

    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    half_sel_e   wr_ptr;
    half_sel_e   rd_ptr;
    half_sel_e   rd_sel;
    half_state_e st [2];
    logic [1:0]  wr_ok;
    logic [1:0]  rd_ok;
    logic [1:0]  wsel;
    logic [1:0]  rsel;

    logic             wr_any;
    logic             wr_addr_ok;
    logic             wr_acc;
    logic [LANES-1:0] rd_addr_ok;
    logic [LANES-1:0] rd_acc;
    logic             rd_any;
    logic             done_acc;
    logic             bad;

    logic [LANES*DW-1:0] hold;
    logic [DW-1:0]       q [2][LANES];

    assign wsel = (wr_ptr == HALF_A) ? 2'b01 : 2'b10;
    assign rsel = (rd_ptr == HALF_A) ? 2'b01 : 2'b10;

    assign wr_ready = |(wr_ok & wsel);
    assign rd_ready = |(rd_ok & rsel);

    assign wr_any     = |wr_en;
    assign wr_addr_ok = ({1'b0, wr_addr} < LIMIT);
    assign wr_acc     = wr_any && wr_ready && wr_addr_ok;

    for (genvar l = 0; l < LANES; l++) begin : g_rdok
        assign rd_addr_ok[l] = ({1'b0, rd_addr[l*AW +: AW]} < LIMIT);
    end

    assign rd_acc   = rd_en & rd_addr_ok & {LANES{rd_ready}};
    assign rd_any   = |rd_acc;
    assign done_acc = rd_done && rd_ready;

    assign bad = (wr_any && (!wr_ready || !wr_addr_ok))
              || (|rd_en && !rd_ready)
              || (|(rd_en & ~rd_addr_ok))
              || (rd_done && !rd_ready);

    for (genvar h = 0; h < 2; h++) begin : g_half
        pingpong_half_fsm u_fsm (
            .clk     (clk),
            .rst     (rst),
            .wr_acc  (wr_acc && wsel[h]),
            .wr_last (wr_last),
            .rd_acc  (rd_any && rsel[h]),
            .done    (done_acc && rsel[h]),
            .state   (st[h]),
            .wr_ok   (wr_ok[h]),
            .rd_ok   (rd_ok[h])
        );

        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic          w;
            logic          r;
            logic [AW-1:0] a;
            logic [DW-1:0] d;

            // Idle macros see CEN high and zeroed pins.
            assign w = wr_acc && wr_en[l] && wsel[h];
            assign r = rd_acc[l] && rsel[h];
            assign a = w ? wr_addr
                     : (r ? rd_addr[l*AW +: AW] : '0);
            assign d = w ? wr_data[l*DW +: DW] : '0;

            pingpong_sram_macro #(
                .DW    (DW),
                .DEPTH (DEPTH)
            ) u_sram (
                .clk (clk),
                .cen (!(w || r)),
                .wen (!w),
                .oen (1'b0),
                .a   (a),
                .d   (d),
                .q   (q[h][l])
            );
        end
    end

    always_comb begin
        full_cnt = 2'd0;
        for (int h = 0; h < 2; h++) begin
            if (st[h] == FULL || st[h] == DRAINING)
                full_cnt = full_cnt + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= HALF_A;
            rd_ptr   <= HALF_A;
            rd_sel   <= HALF_A;
            rd_valid <= '0;
            err      <= 1'b0;
            hold     <= '0;
        end else begin
            if (wr_acc && wr_last)
                wr_ptr <= other_half(wr_ptr);
            if (done_acc)
                rd_ptr <= other_half(rd_ptr);
            if (bad)
                err <= 1'b1;
            rd_sel   <= rd_ptr;
            rd_valid <= rd_acc;
            hold     <= rd_data;
        end
    end

    // Lanes without a fresh read keep their last returned word.
    for (genvar l = 0; l < LANES; l++) begin : g_rdata
        assign rd_data[l*DW +: DW] = rd_valid[l]
                                   ? q[rd_sel == HALF_B][l]
                                   : hold[l*DW +: DW];
    end

endmodule

// File: tb/tb_pingpong_sram_buffer.sv
// Directed bench for pingpong_sram_buffer with hand-derived expectations.
module tb_pingpong_sram_buffer;

    localparam int LANES = 8;
    localparam int DW    = 128;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic                clk = 1'b0;
    logic                rst;
    logic [LANES-1:0]    wr_en;
    logic [AW-1:0]       wr_addr;
    logic [LANES*DW-1:0] wr_data;
    logic                wr_last;
    logic                wr_ready;
    logic [LANES-1:0]    rd_en;
    logic [LANES*AW-1:0] rd_addr;
    logic                rd_done;
    logic                rd_ready;
    logic [LANES-1:0]    rd_valid;
    logic [LANES*DW-1:0] rd_data;
    logic [1:0]          full_cnt;
    logic                err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pingpong_sram_buffer #(
        .LANES (LANES),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_done  (rd_done),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .full_cnt (full_cnt),
        .err      (err)
    );

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input int t, input int l,
                                         input int a);
        logic [127:0] v;
        v = '0;
        v[23:16] = t[7:0];
        v[15:8]  = l[7:0];
        v[7:0]   = a[7:0];
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_last = 1'b0;
        rd_en   = '0;
        rd_addr = '0;
        rd_done = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic fill(input int tag, input bit done_end,
                        input int n, input bit last);
        for (int a = 0; a < n; a++) begin
            wr_en   = '1;
            wr_addr = a[AW-1:0];
            for (int l = 0; l < LANES; l++)
                wr_data[l*DW +: DW] = pat(tag, l, a);
            wr_last = last && (a == n - 1);
            rd_done = done_end && (a == n - 1);
            step();
        end
        idle();
    endtask

    task automatic rd1(input int l, input int a);
        rd_en    = '0;
        rd_en[l] = 1'b1;
        rd_addr[l*AW +: AW] = a[AW-1:0];
        step();
        idle();
    endtask

    function automatic logic [127:0] lane(input int l);
        return rd_data[l*DW +: DW];
    endfunction

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;

        check("rst_wr_ready", 128'(wr_ready), 128'd1);
        check("rst_rd_ready", 128'(rd_ready), 128'd0);
        check("rst_rd_valid", 128'(rd_valid), 128'd0);
        check("rst_rd_data",  128'(|rd_data), 128'd0);
        check("rst_full_cnt", 128'(full_cnt), 128'd0);
        check("rst_err",      128'(err),      128'd0);

        // Reads with nothing filled are dropped.
        rd_en = '1;
        step();
        idle();
        check("early_rd_valid", 128'(rd_valid), 128'd0);
        check("early_rd_err",   128'(err),      128'd1);
        step();
        check("early_rd_valid2", 128'(rd_valid), 128'd0);

        do_reset();
        fill(0, 1'b0, DEPTH, 1'b1);
        check("fa_wr_ready", 128'(wr_ready), 128'd1);
        check("fa_rd_ready", 128'(rd_ready), 128'd1);
        check("fa_full_cnt", 128'(full_cnt), 128'd1);
        check("fa_err",      128'(err),      128'd0);
        rd1(3, 5);
        check("ra_valid", 128'(rd_valid), 128'h08);
        check("ra_data",  lane(3),        pat(0, 3, 5));
        check("ra_hold0", lane(0),        128'd0);
        step();
        check("ra_valid_drop", 128'(rd_valid), 128'd0);
        check("ra_data_held",  lane(3),        pat(0, 3, 5));

        fill(1, 1'b0, DEPTH, 1'b1);
        check("fb_wr_ready", 128'(wr_ready), 128'd0);
        check("fb_full_cnt", 128'(full_cnt), 128'd2);
        check("fb_err",      128'(err),      128'd0);
        wr_en   = '1;
        wr_addr = 7'd5;
        wr_data = '1;
        step();
        idle();
        check("drop_err",      128'(err),      128'd1);
        check("drop_full_cnt", 128'(full_cnt), 128'd2);
        rd1(3, 5);
        check("drop_keep_a", lane(3), pat(0, 3, 5));

        // Last read of A coincides with rd_done.
        rd_en[2] = 1'b1;
        rd_addr[2*AW +: AW] = 7'd9;
        rd_done = 1'b1;
        step();
        idle();
        check("dn_valid",     128'(rd_valid), 128'h04);
        check("dn_data_a",    lane(2),        pat(0, 2, 9));
        check("dn_full_cnt",  128'(full_cnt), 128'd1);
        check("dn_wr_ready",  128'(wr_ready), 128'd1);
        check("dn_rd_ready",  128'(rd_ready), 128'd1);
        rd_en = 8'h84;
        rd_addr[2*AW +: AW] = 7'd9;
        rd_addr[7*AW +: AW] = 7'd127;
        step();
        idle();
        check("rb_valid", 128'(rd_valid), 128'h84);
        check("rb_l2",    lane(2),        pat(1, 2, 9));
        check("rb_l7",    lane(7),        pat(1, 7, 127));

        fill(2, 1'b1, DEPTH, 1'b1);
        check("x1_full_cnt", 128'(full_cnt), 128'd1);
        check("x1_wr_ready", 128'(wr_ready), 128'd1);
        check("x1_rd_ready", 128'(rd_ready), 128'd1);
        rd1(1, 0);
        check("x1_data", lane(1), pat(2, 1, 0));

        fill(3, 1'b1, DEPTH, 1'b1);
        check("x2_full_cnt", 128'(full_cnt), 128'd1);
        check("x2_wr_ready", 128'(wr_ready), 128'd1);
        check("x2_rd_ready", 128'(rd_ready), 128'd1);
        rd1(6, 100);
        check("x2_data", lane(6), pat(3, 6, 100));

        // Reset in the middle of filling B with a read in flight.
        do_reset();
        fill(4, 1'b0, DEPTH, 1'b1);
        rd1(0, 1);
        check("pre_data", lane(0), pat(4, 0, 1));
        fill(5, 1'b0, 10, 1'b0);
        check("mid_wr_ready", 128'(wr_ready), 128'd1);
        rst     = 1'b1;
        wr_en   = '1;
        wr_addr = 7'd10;
        rd_en   = 8'h01;
        step();
        idle();
        rst = 1'b0;
        check("mr_rd_valid", 128'(rd_valid), 128'd0);
        check("mr_rd_data",  128'(|rd_data), 128'd0);
        check("mr_wr_ready", 128'(wr_ready), 128'd1);
        check("mr_rd_ready", 128'(rd_ready), 128'd0);
        check("mr_full_cnt", 128'(full_cnt), 128'd0);
        check("mr_err",      128'(err),      128'd0);
        step();
        check("mr_rd_valid2", 128'(rd_valid), 128'd0);

        fill(6, 1'b0, DEPTH, 1'b1);
        check("nf_rd_ready", 128'(rd_ready), 128'd1);
        check("nf_full_cnt", 128'(full_cnt), 128'd1);
        check("nf_err",      128'(err),      128'd0);
        rd1(4, 64);
        check("nf_valid", 128'(rd_valid), 128'h10);
        check("nf_data",  lane(4),        pat(6, 4, 64));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
